// File: rtl/seq_step_pkg.sv
// Shared encodings for the sequence-index counter: FSM states and end-of-range modes.
package seq_step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

endpackage

// File: rtl/seq_step_next.sv
// Combinational next-index calculation; one extra bit of headroom so an
// overshoot past limit_q is detected instead of silently wrapping mod 2**WIDTH.
module seq_step_next
  import seq_step_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int WRAP_MODE = MODE_SAT
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] limit_q,
  input  logic             up_dn,
  output logic [WIDTH-1:0] next_count,
  output logic             overshoot
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] lim_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    cnt_ext    = {1'b0, count};
    lim_ext    = {1'b0, limit_q};
    sum        = cnt_ext + STEP_EXT;
    next_count = count;
    overshoot  = 1'b0;
    if (up_dn) begin
      if (sum <= lim_ext) begin
        next_count = sum[WIDTH-1:0];
      end else begin
        overshoot  = 1'b1;
        next_count = (WRAP_MODE == MODE_WRAP) ? '0 : limit_q;
      end
    end else begin
      if (cnt_ext >= STEP_EXT) begin
        next_count = count - STEP_EXT[WIDTH-1:0];
      end else begin
        overshoot  = 1'b1;
        next_count = (WRAP_MODE == MODE_WRAP) ? limit_q : '0;
      end
    end
  end

endmodule

// File: rtl/seq_step_counter.sv
// Registered pattern/playback index counter: IDLE/RUN/DONE control with a limit
// captured on start/load, stepping by STEP per inc and saturating or wrapping at the ends.
module seq_step_counter
  import seq_step_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int WRAP_MODE = MODE_SAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             inc,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             wrap_p,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] limit_reg, limit_next;
  logic             terminal_reg, terminal_next;
  logic             wrap_reg, wrap_next;

  logic [WIDTH-1:0] step_count;
  logic             overshoot;
  logic [WIDTH-1:0] load_count;
  logic             recalc_term;

  seq_step_next #(
    .WIDTH    (WIDTH),
    .STEP     (STEP),
    .WRAP_MODE(WRAP_MODE)
  ) u_next (
    .count     (count_reg),
    .limit_q   (limit_reg),
    .up_dn     (up_dn),
    .next_count(step_count),
    .overshoot (overshoot)
  );

  assign load_count = (load_val < limit) ? load_val : limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      limit_reg    <= '0;
      terminal_reg <= 1'b0;
      wrap_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      limit_reg    <= limit_next;
      terminal_reg <= terminal_next;
      wrap_reg     <= wrap_next;
    end
  end

  // terminal is only re-evaluated on an accepted start/load/inc; it holds otherwise
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    limit_next    = limit_reg;
    terminal_next = terminal_reg;
    wrap_next     = 1'b0;
    recalc_term   = 1'b0;
    if (clear) begin
      state_next    = ST_IDLE;
      count_next    = '0;
      terminal_next = 1'b0;
    end else if (start) begin
      state_next  = ST_RUN;
      limit_next  = limit;
      count_next  = up_dn ? '0 : limit;
      recalc_term = 1'b1;
    end else if (load) begin
      state_next  = ST_RUN;
      limit_next  = limit;
      count_next  = load_count;
      recalc_term = 1'b1;
    end else if (inc && state_reg == ST_RUN) begin
      count_next  = step_count;
      recalc_term = 1'b1;
      if (overshoot) begin
        if (WRAP_MODE == MODE_WRAP) wrap_next = 1'b1;
        else state_next = ST_DONE;
      end
    end
    if (recalc_term) begin
      terminal_next = up_dn ? (count_next == limit_next) : (count_next == '0);
    end
  end

  assign count    = count_reg;
  assign terminal = terminal_reg;
  assign wrap_p   = wrap_reg;
  assign busy     = (state_reg == ST_RUN);
  assign done     = (state_reg == ST_DONE);

endmodule
